xadc_sample_to_bcd: RTL and testbench

- Sequential scaling and binary-to-BCD stage between the XADC DRP read path (`do_out`/`drdy_out`) and the 8-digit seven-segment driver.
- Accepts one 16-bit XADC conversion result and takes the 12-bit code in bits [15:4].
- Scales the code to a microvolt-style decimal value (full scale 1.000000 V) and converts it to 7 BCD digits with an iterative double-dabble engine.
- Replaces the combinational divide/modulo chain; results are presented with a one-cycle valid pulse.

---
 rtl/xadc_disp_pkg.sv | 22 ++
 rtl/bcd_add3_stage.sv | 21 ++
 rtl/xadc_sample_to_bcd.sv | 122 ++++++++++++
 tb/tb_xadc_sample_to_bcd.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/xadc_disp_pkg.sv
// Shared FSM encoding and default constants for the XADC sample-to-BCD stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package xadc_disp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCALE   = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int SCALE_MUL   = 250000;
    localparam int SCALE_SHIFT = 10;
    localparam int SAT_THRESH  = 4093;
    localparam int BIN_W       = 20;
    localparam int NUM_DIGITS  = 7;

    // Value forced out for codes at or above the saturation threshold (1.000000 V)
    localparam int SAT_VALUE   = 1000000;

endpackage

// File: rtl/bcd_add3_stage.sv
// Double-dabble correction: adds 3 to every BCD nibble that is 5 or more.
// Latency: combinational.
// Backpressure: none.
module bcd_add3_stage #(
    parameter int NUM_DIGITS = 7
) (
    input  logic [4*NUM_DIGITS-1:0] din,
    output logic [4*NUM_DIGITS-1:0] dout
);

    // Each nibble is corrected independently so the following left shift carries correctly
    always_comb begin
        dout = din;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (din[4*i +: 4] >= 4'd5) begin
                dout[4*i +: 4] = din[4*i +: 4] + 4'd3;
            end
        end
    end

endmodule

// File: rtl/xadc_sample_to_bcd.sv
// Scales a 12-bit XADC code to microvolts (1.000000 V full scale) and converts it to 7 BCD digits.
// Latency: accept edge 0 -> out_valid pulse after edge 22; next accept possible at edge 23.
// Backpressure: in_ready high only in IDLE; in_valid outside IDLE is dropped. Optional
// XADC_BCD_AVG_EN: averages 4 accepted samples and produces one result per group of 4.
module xadc_sample_to_bcd #(
    parameter int SCALE_MUL   = xadc_disp_pkg::SCALE_MUL,
    parameter int SCALE_SHIFT = xadc_disp_pkg::SCALE_SHIFT,
    parameter int SAT_THRESH  = xadc_disp_pkg::SAT_THRESH,
    parameter int BIN_W       = xadc_disp_pkg::BIN_W,
    parameter int NUM_DIGITS  = xadc_disp_pkg::NUM_DIGITS
) (
    input  logic                    CLK100MHZ,
    input  logic                    rst_n,
    input  logic [15:0]             sample_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    out_valid,
    output logic                    busy
);
    import xadc_disp_pkg::*;

    localparam int BCD_W  = 4 * NUM_DIGITS;
    localparam int CNT_W  = $clog2(BIN_W);
    localparam int PROD_W = 30;
    localparam logic [11:0]      SAT_CODE = 12'(SAT_THRESH);
    localparam logic [BIN_W-1:0] SAT_BIN  = BIN_W'(SAT_VALUE);

    state_t             state;
    logic [11:0]        code;
    logic [BIN_W-1:0]   bin;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [CNT_W-1:0]   cnt;
    logic [PROD_W-1:0]  product;
    logic [BIN_W-1:0]   scaled;

`ifdef XADC_BCD_AVG_EN
    logic [13:0]        avg_sum;
    logic [1:0]         avg_cnt;
    logic [13:0]        sum_next;

    // Running sum including the sample currently offered
    assign sum_next = avg_sum + {2'b00, sample_in[15:4]};
`endif

    // Handshake/status flags derive straight from the state register
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // 12x18 product fits in 30 bits for every code; saturate near full scale
    assign product = PROD_W'(code) * PROD_W'(SCALE_MUL);
    assign scaled  = (code >= SAT_CODE) ? SAT_BIN : BIN_W'(product >> SCALE_SHIFT);

    bcd_add3_stage #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_add3 (
        .din  (acc),
        .dout (acc_adj)
    );

    // Control FSM plus the scale/double-dabble datapath; bcd_out only updates in DONE
    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            state     <= IDLE;
            code      <= '0;
            bin       <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            out_valid <= 1'b0;
`ifdef XADC_BCD_AVG_EN
            avg_sum   <= '0;
            avg_cnt   <= '0;
`endif
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef XADC_BCD_AVG_EN
                        if (avg_cnt == 2'd3) begin
                            code    <= sum_next[13:2];
                            avg_sum <= '0;
                            avg_cnt <= '0;
                            state   <= SCALE;
                        end else begin
                            avg_sum <= sum_next;
                            avg_cnt <= avg_cnt + 2'd1;
                        end
`else
                        code  <= sample_in[15:4];
                        state <= SCALE;
`endif
                    end
                end
                SCALE: begin
                    bin   <= scaled;
                    acc   <= '0;
                    cnt   <= CNT_W'(BIN_W - 1);
                    state <= CONVERT;
                end
                CONVERT: begin
                    acc <= {acc_adj[BCD_W-2:0], bin[BIN_W-1]};
                    bin <= {bin[BIN_W-2:0], 1'b0};
                    if (cnt == '0) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    bcd_out   <= acc;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_sample_to_bcd.sv
// Directed bench for xadc_sample_to_bcd: reset state, scaling points, saturation,
// streaming with in_valid held high, and reset during a conversion.
module tb_xadc_sample_to_bcd;

    logic        clk;
    logic        rst_n;
    logic [15:0] sample_in;
    logic        in_valid;
    logic        in_ready;
    logic [27:0] bcd_out;
    logic        out_valid;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    xadc_sample_to_bcd dut (
        .CLK100MHZ (clk),
        .rst_n     (rst_n),
        .sample_in (sample_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Decimal reference: scale, saturate, then peel off digits by division
    function automatic logic [27:0] ref_bcd(input int code);
        int v;
        logic [27:0] r;
        v = (code >= 4093) ? 1000000 : (code * 250000) / 1024;
        r = '0;
        for (int d = 0; d < 7; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Offer one sample for a single cycle and wait for its result
    task automatic send_and_wait(input string tag, input logic [15:0] data, input logic [27:0] exp);
        int lat;
        bit found;
        @(negedge clk);
        check({tag, "_rdy"}, 32'(in_ready), 32'd1);
        sample_in = data;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        found = 0;
        while (!found && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) found = 1;
        end
        check({tag, "_lat"}, found ? 32'(lat) : 32'hDEAD, 32'd22);
        check({tag, "_bcd"}, 32'(bcd_out), 32'(exp));
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    // Offer one sample for a single cycle without waiting for any output
    task automatic push_only(input logic [15:0] data);
        @(negedge clk);
        sample_in = data;
        in_valid  = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_out;
        int overlap;
        int acc_idx[$];
        logic [27:0] exp_q[$];
        logic [15:0] d;

        rst_n     = 1'b0;
        sample_in = '0;
        in_valid  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        check("rst_bcd",   32'(bcd_out),   32'h0);
        check("rst_ovld",  32'(out_valid), 32'd0);
        check("rst_rdy",   32'(in_ready),  32'd1);
        check("rst_busy",  32'(busy),      32'd0);

`ifdef XADC_BCD_AVG_EN
        // codes 100,200,300,400 average to 250
        n_out = 0;
        push_only(16'h0640);
        push_only(16'h0C80);
        push_only(16'h12C0);
        repeat (5) begin
            @(negedge clk);
            if (out_valid) n_out++;
        end
        check("avg_early", 32'(n_out), 32'd0);
        send_and_wait("avg250", 16'h1900, 28'h0061035);
        for (int i = 0; i < 3; i++) push_only(16'hFFC0);
        send_and_wait("avg4092", 16'hFFC0, 28'h0999023);
        for (int i = 0; i < 3; i++) push_only(16'hFFF0);
        send_and_wait("avg4095", 16'hFFF0, 28'h1000000);
`else
        send_and_wait("half",  16'h8000, 28'h0500000);
        send_and_wait("code1", 16'h0010, 28'h0000244);
        send_and_wait("c4092", 16'hFFC0, 28'h0999023);
        send_and_wait("c4095", 16'hFFF0, 28'h1000000);
        send_and_wait("c4093", 16'hFFD0, 28'h1000000);
        send_and_wait("c0",    16'h000F, 28'h0000000);

        // in_valid held high for 60 cycles with changing data
        n_out = 0;
        overlap = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            d = 16'h1234 + 16'(i * 16'h0531);
            sample_in = d;
            in_valid  = 1'b1;
            if (busy && in_ready) overlap++;
            if (in_ready) begin
                acc_idx.push_back(i);
                exp_q.push_back(ref_bcd(int'(d[15:4])));
            end
            @(posedge clk);
            #1;
            if (out_valid) begin
                n_out++;
                if (exp_q.size() > 0) check("strm_bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
                else check("strm_extra", 32'd1, 32'd0);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (busy && in_ready) overlap++;
            if (out_valid) begin
                n_out++;
                if (exp_q.size() > 0) check("strm_bcd", 32'(bcd_out), 32'(exp_q.pop_front()));
                else check("strm_extra", 32'd1, 32'd0);
            end
        end
        check("strm_nout",  32'(n_out),          32'd3);
        check("strm_nacc",  32'(acc_idx.size()), 32'd3);
        check("strm_ovlp",  32'(overlap),        32'd0);
        if (acc_idx.size() == 3) begin
            check("strm_acc1", 32'(acc_idx[1]), 32'd23);
            check("strm_acc2", 32'(acc_idx[2]), 32'd46);
        end

        // reset in the middle of a conversion discards it
        n_out = 0;
        push_only(16'h8000);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (out_valid) n_out++;
            if (k == 9)  rst_n = 1'b0;
            if (k == 10) rst_n = 1'b1;
        end
        check("mrst_nout", 32'(n_out),    32'd0);
        check("mrst_bcd",  32'(bcd_out),  32'h0);
        check("mrst_rdy",  32'(in_ready), 32'd1);
        send_and_wait("post_rst", 16'h0010, 28'h0000244);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
